// File: rtl/mem_port_arbiter.sv
// Word-level arbiter/sequencer that shares the byte-serial RAM engine between
// fetch, load and store requesters (store > load > fetch, with fetch anti-starvation).
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int IO_GAP       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        in_xbp,
    input  logic        in_uart_full,
    input  logic        in_fetch_req,
    input  logic [31:0] in_fetch_addr,
    input  logic        in_ld_req,
    input  logic [31:0] in_ld_addr,
    input  logic [2:0]  in_ld_size,
    input  logic        in_ld_sign,
    input  logic        in_st_req,
    input  logic [31:0] in_st_addr,
    input  logic [2:0]  in_st_size,
    input  logic [31:0] in_st_data,
    output logic        out_fetch_done,
    output logic        out_ld_done,
    output logic        out_st_done,
    output logic [31:0] out_rdata,
    output logic        out_eng_valid,
    output logic        out_eng_write,
    output logic [31:0] out_eng_addr,
    output logic [2:0]  out_eng_size,
    output logic        out_eng_sign,
    output logic [31:0] out_eng_wdata,
    input  logic        in_eng_done,
    input  logic [31:0] in_eng_rdata
);
    typedef enum logic [1:0] {IDLE, IO_HOLD, BUSY, DRAIN} state_t;
    typedef enum logic [1:0] {K_FETCH, K_LOAD, K_STORE} kind_t;

    localparam int SW = $clog2(STARVE_LIMIT + 2);
    localparam int GW = $clog2(IO_GAP + 2);

    function automatic logic [2:0] norm_size(input logic [2:0] sz);
        case (sz)
            3'd1:    return 3'd1;
            3'd2:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic is_io(input logic [1:0] seg);
        return seg == 2'b11;
    endfunction

    state_t        state_q, state_d;
    kind_t         kind_q, kind_d;
    logic          io_q, io_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          eng_valid_q, eng_valid_d;
    logic          eng_write_q, eng_write_d;
    logic [31:0]   eng_addr_q, eng_addr_d;
    logic [2:0]    eng_size_q, eng_size_d;
    logic          eng_sign_q, eng_sign_d;
    logic [31:0]   eng_wdata_q, eng_wdata_d;
    logic          fetch_done_q, fetch_done_d;
    logic          ld_done_q, ld_done_d;
    logic          st_done_q, st_done_d;
    logic [31:0]   rdata_q, rdata_d;

    logic fetch_ok, ld_ok, st_ok, any_done;
    logic win_fetch, win_ld, win_st;

    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        io_d         = io_q;
        starve_d     = starve_q;
        gap_d        = gap_q;
        eng_valid_d  = 1'b0;
        eng_write_d  = eng_write_q;
        eng_addr_d   = eng_addr_q;
        eng_size_d   = eng_size_q;
        eng_sign_d   = eng_sign_q;
        eng_wdata_d  = eng_wdata_q;
        fetch_done_d = 1'b0;
        ld_done_d    = 1'b0;
        st_done_d    = 1'b0;
        rdata_d      = rdata_q;
        win_fetch    = 1'b0;
        win_ld       = 1'b0;
        win_st       = 1'b0;

        // Requests are still high while their done pulse is out; granting then would repeat them.
        any_done = fetch_done_q | ld_done_q | st_done_q;
        fetch_ok = in_fetch_req & ~in_xbp;
        ld_ok    = in_ld_req & ~in_xbp;
        st_ok    = in_st_req;

        if (gap_q != '0) gap_d = gap_q - 1'b1;

        case (state_q)
            IDLE: begin
                if (!any_done) begin
                    if (fetch_ok && starve_q >= SW'(STARVE_LIMIT)) win_fetch = 1'b1;
                    else if (st_ok)                                win_st    = 1'b1;
                    else if (ld_ok)                                win_ld    = 1'b1;
                    else if (fetch_ok)                             win_fetch = 1'b1;
                end
                if (win_st) begin
                    kind_d      = K_STORE;
                    io_d        = is_io(in_st_addr[17:16]);
                    eng_write_d = 1'b1;
                    eng_addr_d  = in_st_addr;
                    eng_size_d  = norm_size(in_st_size);
                    eng_sign_d  = 1'b0;
                    eng_wdata_d = in_st_data;
                    if (is_io(in_st_addr[17:16]) && (in_uart_full || gap_q != '0)) begin
                        state_d = IO_HOLD;
                    end else begin
                        state_d     = BUSY;
                        eng_valid_d = 1'b1;
                    end
                end else if (win_ld) begin
                    kind_d      = K_LOAD;
                    io_d        = 1'b0;
                    eng_write_d = 1'b0;
                    eng_addr_d  = in_ld_addr;
                    eng_size_d  = norm_size(in_ld_size);
                    eng_sign_d  = in_ld_sign;
                    eng_wdata_d = '0;
                    state_d     = BUSY;
                    eng_valid_d = 1'b1;
                end else if (win_fetch) begin
                    kind_d      = K_FETCH;
                    io_d        = 1'b0;
                    eng_write_d = 1'b0;
                    eng_addr_d  = in_fetch_addr;
                    eng_size_d  = 3'd4;
                    eng_sign_d  = 1'b0;
                    eng_wdata_d = '0;
                    state_d     = BUSY;
                    eng_valid_d = 1'b1;
                end
            end
            IO_HOLD: begin
                if (!in_uart_full && gap_q == '0) begin
                    state_d     = BUSY;
                    eng_valid_d = 1'b1;
                end
            end
            BUSY: begin
                if (kind_q == K_STORE) begin
                    if (in_eng_done) begin
                        st_done_d = 1'b1;
                        state_d   = IDLE;
                        if (io_q) gap_d = GW'(IO_GAP);
                    end
                end else if (in_xbp) begin
                    state_d = in_eng_done ? IDLE : DRAIN;
                end else if (in_eng_done) begin
                    state_d = IDLE;
                    rdata_d = in_eng_rdata;
                    if (kind_q == K_FETCH) fetch_done_d = 1'b1;
                    else                   ld_done_d    = 1'b1;
                end
            end
            DRAIN: begin
                if (in_eng_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (in_xbp || !in_fetch_req || win_fetch)
            starve_d = '0;
        else if ((win_st || win_ld) && starve_q < SW'(STARVE_LIMIT))
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            kind_q       <= K_FETCH;
            io_q         <= 1'b0;
            starve_q     <= '0;
            gap_q        <= '0;
            eng_valid_q  <= 1'b0;
            eng_write_q  <= 1'b0;
            eng_addr_q   <= '0;
            eng_size_q   <= '0;
            eng_sign_q   <= 1'b0;
            eng_wdata_q  <= '0;
            fetch_done_q <= 1'b0;
            ld_done_q    <= 1'b0;
            st_done_q    <= 1'b0;
            rdata_q      <= '0;
        end else if (rdy) begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            io_q         <= io_d;
            starve_q     <= starve_d;
            gap_q        <= gap_d;
            eng_valid_q  <= eng_valid_d;
            eng_write_q  <= eng_write_d;
            eng_addr_q   <= eng_addr_d;
            eng_size_q   <= eng_size_d;
            eng_sign_q   <= eng_sign_d;
            eng_wdata_q  <= eng_wdata_d;
            fetch_done_q <= fetch_done_d;
            ld_done_q    <= ld_done_d;
            st_done_q    <= st_done_d;
            rdata_q      <= rdata_d;
        end
    end

    assign out_fetch_done = fetch_done_q;
    assign out_ld_done    = ld_done_q;
    assign out_st_done    = st_done_q;
    assign out_rdata      = rdata_q;
    assign out_eng_valid  = eng_valid_q;
    assign out_eng_write  = eng_write_q;
    assign out_eng_addr   = eng_addr_q;
    assign out_eng_size   = eng_size_q;
    assign out_eng_sign   = eng_sign_q;
    assign out_eng_wdata  = eng_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs driven and outputs sampled on the falling edge,
// engine responses scripted by hand per scenario.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst, rdy, in_xbp, in_uart_full;
    logic        in_fetch_req, in_ld_req, in_ld_sign, in_st_req;
    logic [31:0] in_fetch_addr, in_ld_addr, in_st_addr, in_st_data;
    logic [2:0]  in_ld_size, in_st_size;
    logic        out_fetch_done, out_ld_done, out_st_done;
    logic [31:0] out_rdata;
    logic        out_eng_valid, out_eng_write, out_eng_sign;
    logic [31:0] out_eng_addr, out_eng_wdata;
    logic [2:0]  out_eng_size;
    logic        in_eng_done;
    logic [31:0] in_eng_rdata;

    int checks = 0;
    int failures = 0;
    int nvalid = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(4), .IO_GAP(2)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .in_xbp(in_xbp), .in_uart_full(in_uart_full),
        .in_fetch_req(in_fetch_req), .in_fetch_addr(in_fetch_addr),
        .in_ld_req(in_ld_req), .in_ld_addr(in_ld_addr), .in_ld_size(in_ld_size), .in_ld_sign(in_ld_sign),
        .in_st_req(in_st_req), .in_st_addr(in_st_addr), .in_st_size(in_st_size), .in_st_data(in_st_data),
        .out_fetch_done(out_fetch_done), .out_ld_done(out_ld_done), .out_st_done(out_st_done),
        .out_rdata(out_rdata), .out_eng_valid(out_eng_valid), .out_eng_write(out_eng_write),
        .out_eng_addr(out_eng_addr), .out_eng_size(out_eng_size), .out_eng_sign(out_eng_sign),
        .out_eng_wdata(out_eng_wdata), .in_eng_done(in_eng_done), .in_eng_rdata(in_eng_rdata)
    );

    task automatic tick();
        @(negedge clk);
        if (out_eng_valid === 1'b1) nvalid++;
    endtask

    task automatic eng_complete(input int lat, input logic [31:0] rd);
        for (int i = 1; i < lat; i++) tick();
        in_eng_done = 1'b1;
        in_eng_rdata = rd;
        tick();
        in_eng_done = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int n, output logic found);
        found = 1'b0;
        n = 0;
        while (!found && n < budget) begin
            tick();
            n++;
            if (out_eng_valid === 1'b1) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; rdy = 1'b1; in_xbp = 1'b0; in_uart_full = 1'b0;
        in_fetch_req = 1'b0; in_fetch_addr = '0; in_ld_req = 1'b0; in_ld_addr = '0;
        in_ld_size = '0; in_ld_sign = 1'b0; in_st_req = 1'b0; in_st_addr = '0;
        in_st_size = '0; in_st_data = '0; in_eng_done = 1'b0; in_eng_rdata = '0;
        repeat (3) tick();
        checks++; if ({out_eng_valid, out_fetch_done, out_ld_done, out_st_done} !== 4'b0) begin
            failures++; $display("FAIL reset_pulses: got %b want 0000", {out_eng_valid, out_fetch_done, out_ld_done, out_st_done}); end
        checks++; if (out_rdata !== 32'h0 || out_eng_addr !== 32'h0) begin
            failures++; $display("FAIL reset_data: rdata=%h addr=%h want 0", out_rdata, out_eng_addr); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_fetch();
        int v0;
        v0 = nvalid;
        in_fetch_req = 1'b1; in_fetch_addr = 32'h1000;
        tick();
        checks++; if (out_eng_valid !== 1'b1 || out_eng_addr !== 32'h1000 || out_eng_write !== 1'b0 || out_eng_size !== 3'd4) begin
            failures++; $display("FAIL fetch_issue: valid=%b addr=%h write=%b size=%0d want 1 1000 0 4", out_eng_valid, out_eng_addr, out_eng_write, out_eng_size); end
        eng_complete(4, 32'hDEADBEEF);
        checks++; if (out_fetch_done !== 1'b1 || out_rdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL fetch_done: done=%b rdata=%h want 1 deadbeef", out_fetch_done, out_rdata); end
        in_fetch_req = 1'b0;
        tick();
        checks++; if (out_fetch_done !== 1'b0 || out_rdata !== 32'hDEADBEEF || nvalid - v0 != 1) begin
            failures++; $display("FAIL fetch_after: done=%b rdata=%h valids=%0d want 0 deadbeef 1", out_fetch_done, out_rdata, nvalid - v0); end
    endtask

    task automatic test_priority();
        int v0, n;
        logic found;
        v0 = nvalid;
        in_st_req = 1'b1; in_st_addr = 32'h100; in_st_size = 3'd3; in_st_data = 32'h12345678;
        in_ld_req = 1'b1; in_ld_addr = 32'h200; in_ld_size = 3'd1; in_ld_sign = 1'b0;
        in_fetch_req = 1'b1; in_fetch_addr = 32'h300;
        tick();
        checks++; if (out_eng_valid !== 1'b1 || out_eng_write !== 1'b1 || out_eng_addr !== 32'h100 || out_eng_size !== 3'd4 || out_eng_wdata !== 32'h12345678) begin
            failures++; $display("FAIL prio_store: valid=%b write=%b addr=%h size=%0d wdata=%h want 1 1 100 4 12345678", out_eng_valid, out_eng_write, out_eng_addr, out_eng_size, out_eng_wdata); end
        eng_complete(2, 32'h0);
        checks++; if (out_st_done !== 1'b1) begin failures++; $display("FAIL prio_st_done: got %b want 1", out_st_done); end
        in_st_req = 1'b0;
        wait_valid(6, n, found);
        checks++; if (!found || out_eng_write !== 1'b0 || out_eng_addr !== 32'h200 || out_eng_size !== 3'd1) begin
            failures++; $display("FAIL prio_load: found=%b write=%b addr=%h size=%0d want 1 0 200 1", found, out_eng_write, out_eng_addr, out_eng_size); end
        eng_complete(2, 32'h11112222);
        checks++; if (out_ld_done !== 1'b1 || out_rdata !== 32'h11112222) begin
            failures++; $display("FAIL prio_ld_done: done=%b rdata=%h want 1 11112222", out_ld_done, out_rdata); end
        in_ld_req = 1'b0;
        wait_valid(6, n, found);
        checks++; if (!found || out_eng_write !== 1'b0 || out_eng_addr !== 32'h300) begin
            failures++; $display("FAIL prio_fetch: found=%b write=%b addr=%h want 1 0 300", found, out_eng_write, out_eng_addr); end
        eng_complete(2, 32'h33334444);
        checks++; if (out_fetch_done !== 1'b1 || out_rdata !== 32'h33334444) begin
            failures++; $display("FAIL prio_f_done: done=%b rdata=%h want 1 33334444", out_fetch_done, out_rdata); end
        in_fetch_req = 1'b0;
        tick();
        checks++; if (nvalid - v0 != 3) begin failures++; $display("FAIL prio_valid_count: got %0d want 3", nvalid - v0); end
    endtask

    task automatic test_starvation();
        int n, stores;
        logic found;
        stores = 0;
        in_fetch_req = 1'b1; in_fetch_addr = 32'h400;
        in_st_req = 1'b1; in_st_addr = 32'h500; in_st_size = 3'd4; in_st_data = 32'hABCD0000;
        for (int i = 0; i < 4; i++) begin
            wait_valid(6, n, found);
            if (found && out_eng_write === 1'b1) stores++;
            eng_complete(1, 32'h0);
        end
        checks++; if (stores != 4) begin failures++; $display("FAIL starve_stores: got %0d want 4", stores); end
        wait_valid(6, n, found);
        checks++; if (!found || out_eng_write !== 1'b0 || out_eng_addr !== 32'h400) begin
            failures++; $display("FAIL starve_fetch: found=%b write=%b addr=%h want 1 0 400", found, out_eng_write, out_eng_addr); end
        in_st_req = 1'b0;
        eng_complete(1, 32'hCAFEF00D);
        checks++; if (out_fetch_done !== 1'b1 || out_rdata !== 32'hCAFEF00D) begin
            failures++; $display("FAIL starve_f_done: done=%b rdata=%h want 1 cafef00d", out_fetch_done, out_rdata); end
        in_fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_io_backoff();
        int v0, n;
        logic found;
        v0 = nvalid;
        in_uart_full = 1'b1;
        in_st_req = 1'b1; in_st_addr = 32'h30000; in_st_size = 3'd1; in_st_data = 32'h41;
        repeat (10) tick();
        checks++; if (nvalid - v0 != 0 || out_st_done !== 1'b0) begin
            failures++; $display("FAIL io_held: valids=%0d st_done=%b want 0 0", nvalid - v0, out_st_done); end
        in_uart_full = 1'b0;
        tick();
        checks++; if (out_eng_valid !== 1'b1 || out_eng_addr !== 32'h30000 || out_eng_size !== 3'd1) begin
            failures++; $display("FAIL io_issue: valid=%b addr=%h size=%0d want 1 30000 1", out_eng_valid, out_eng_addr, out_eng_size); end
        eng_complete(2, 32'h0);
        checks++; if (out_st_done !== 1'b1) begin failures++; $display("FAIL io_st_done: got %b want 1", out_st_done); end
        in_st_addr = 32'h30004; in_st_data = 32'h42;
        wait_valid(8, n, found);
        checks++; if (!found || n < 2 || out_eng_addr !== 32'h30004) begin
            failures++; $display("FAIL io_gap: found=%b cycles=%0d addr=%h want found, >=2, 30004", found, n, out_eng_addr); end
        eng_complete(1, 32'h0);
        checks++; if (out_st_done !== 1'b1) begin failures++; $display("FAIL io_st_done2: got %b want 1", out_st_done); end
        in_st_req = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_xbp();
        int v0, n;
        logic found;
        in_ld_req = 1'b1; in_ld_addr = 32'h2000; in_ld_size = 3'd2; in_ld_sign = 1'b1;
        tick();
        checks++; if (out_eng_valid !== 1'b1 || out_eng_size !== 3'd2 || out_eng_sign !== 1'b1) begin
            failures++; $display("FAIL xbp_ld_issue: valid=%b size=%0d sign=%b want 1 2 1", out_eng_valid, out_eng_size, out_eng_sign); end
        in_xbp = 1'b1; in_ld_req = 1'b0; in_fetch_req = 1'b1; in_fetch_addr = 32'h600;
        v0 = nvalid;
        tick();
        in_xbp = 1'b0;
        repeat (2) tick();
        in_eng_done = 1'b1; in_eng_rdata = 32'h55555555;
        tick();
        in_eng_done = 1'b0;
        checks++; if (out_ld_done !== 1'b0 || out_fetch_done !== 1'b0 || nvalid - v0 != 0) begin
            failures++; $display("FAIL xbp_drain: ld_done=%b f_done=%b valids=%0d want 0 0 0", out_ld_done, out_fetch_done, nvalid - v0); end
        wait_valid(4, n, found);
        checks++; if (!found || out_eng_addr !== 32'h600 || out_rdata !== 32'hCAFEF00D) begin
            failures++; $display("FAIL xbp_next: found=%b addr=%h rdata=%h want 1 600 cafef00d", found, out_eng_addr, out_rdata); end
        eng_complete(1, 32'h600D600D);
        checks++; if (out_fetch_done !== 1'b1 || out_rdata !== 32'h600D600D) begin
            failures++; $display("FAIL xbp_f_done: done=%b rdata=%h want 1 600d600d", out_fetch_done, out_rdata); end
        in_fetch_req = 1'b0;
        tick();
        in_xbp = 1'b1; in_ld_req = 1'b1; in_ld_addr = 32'h2100; in_ld_size = 3'd4; in_ld_sign = 1'b0;
        tick();
        checks++; if (out_eng_valid !== 1'b0) begin failures++; $display("FAIL xbp_idle_block: valid=%b want 0", out_eng_valid); end
        in_xbp = 1'b0;
        tick();
        checks++; if (out_eng_valid !== 1'b1 || out_eng_addr !== 32'h2100) begin
            failures++; $display("FAIL xbp_idle_release: valid=%b addr=%h want 1 2100", out_eng_valid, out_eng_addr); end
        eng_complete(1, 32'h77778888);
        checks++; if (out_ld_done !== 1'b1 || out_rdata !== 32'h77778888) begin
            failures++; $display("FAIL xbp_ld_done: done=%b rdata=%h want 1 77778888", out_ld_done, out_rdata); end
        in_ld_req = 1'b0;
        tick();
        in_st_req = 1'b1; in_st_addr = 32'h700; in_st_size = 3'd2; in_st_data = 32'h0000BEEF;
        tick();
        checks++; if (out_eng_valid !== 1'b1 || out_eng_write !== 1'b1) begin
            failures++; $display("FAIL xbp_st_issue: valid=%b write=%b want 1 1", out_eng_valid, out_eng_write); end
        in_xbp = 1'b1;
        tick();
        in_xbp = 1'b0;
        eng_complete(2, 32'h0);
        checks++; if (out_st_done !== 1'b1) begin failures++; $display("FAIL xbp_st_done: got %b want 1", out_st_done); end
        in_st_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_busy();
        in_ld_req = 1'b1; in_ld_addr = 32'h800; in_ld_size = 3'd2; in_ld_sign = 1'b1;
        tick();
        in_ld_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        checks++; if ({out_eng_valid, out_eng_write, out_eng_sign, out_fetch_done, out_ld_done, out_st_done} !== 6'b0
                      || out_eng_addr !== 32'h0 || out_eng_size !== 3'd0 || out_eng_wdata !== 32'h0 || out_rdata !== 32'h0) begin
            failures++; $display("FAIL reset_busy: addr=%h size=%0d rdata=%h valid=%b want all 0", out_eng_addr, out_eng_size, out_rdata, out_eng_valid); end
        rst = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_rdy_freeze();
        int frozen_ok;
        frozen_ok = 0;
        in_st_req = 1'b1; in_st_addr = 32'h900; in_st_size = 3'd1; in_st_data = 32'hA5A5A5A5;
        tick();
        checks++; if (out_eng_valid !== 1'b1 || out_eng_addr !== 32'h900) begin
            failures++; $display("FAIL rdy_issue: valid=%b addr=%h want 1 900", out_eng_valid, out_eng_addr); end
        rdy = 1'b0; in_eng_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_eng_valid === 1'b1 && out_eng_addr === 32'h900 && out_eng_wdata === 32'hA5A5A5A5 && out_st_done === 1'b0) frozen_ok++;
        end
        checks++; if (frozen_ok != 5) begin failures++; $display("FAIL rdy_frozen: held cycles=%0d want 5", frozen_ok); end
        in_eng_done = 1'b0; rdy = 1'b1;
        tick();
        checks++; if (out_eng_valid !== 1'b0 || out_st_done !== 1'b0) begin
            failures++; $display("FAIL rdy_resume: valid=%b st_done=%b want 0 0", out_eng_valid, out_st_done); end
        eng_complete(1, 32'h0);
        checks++; if (out_st_done !== 1'b1) begin failures++; $display("FAIL rdy_st_done: got %b want 1", out_st_done); end
        in_st_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_priority();
        test_starvation();
        test_io_backoff();
        test_xbp();
        test_reset_busy();
        test_rdy_freeze();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
